alu_op_issuer: RTL

- Front-end encoder for the 3-bit ALU control interface (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA).
- Accepts RV32I instruction fields plus operand values over a valid/ready handshake, then decodes the ALU control code and selects the two ALU operands.
- Buffers decoded operations in a 2-entry FIFO and presents them to the ALU stage over a second valid/ready handshake.
- Flags any instruction the ALU cannot execute.

---
 rtl/alu_op_issuer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_op_issuer.sv
// RV32I front-end issuer: decodes instruction fields into an ALU control code and operands,
// queues them in a small FIFO and hands them to the ALU stage over a valid/ready handshake.
module alu_op_issuer #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [2:0]      alu_ctrl,
    output logic            illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SRA = 3'd7;

    typedef struct packed {
        logic            ill;
        logic [2:0]      ctrl;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
    } entry_t;

    logic            is_r;
    logic            f7_zero;
    logic            f7_alt;
    logic            dec_ill;
    logic [2:0]      dec_ctrl;
    logic [XLEN-1:0] dec_in1;
    logic [XLEN-1:0] dec_in2;

    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    entry_t          mem [DEPTH];
    entry_t          head;

    assign is_r    = (opcode == OP_R);
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    always_comb begin
        dec_ill  = 1'b0;
        dec_ctrl = ALU_ADD;
        dec_in1  = '0;
        dec_in2  = '0;
        case (opcode)
            OP_R, OP_I: begin
                dec_in1 = rs1_data;
                dec_in2 = is_r ? rs2_data : imm;
                case (funct3)
                    3'b000: begin
                        // funct7 only qualifies R-type; for ADDI those bits belong to the immediate
                        if (is_r && f7_alt)
                            dec_ctrl = ALU_SUB;
                        else if (is_r && !f7_zero)
                            dec_ill = 1'b1;
                    end
                    3'b001: begin
                        dec_ctrl = ALU_SLL;
                        dec_ill  = !f7_zero;
                    end
                    3'b100: begin
                        dec_ctrl = ALU_XOR;
                        dec_ill  = is_r && !f7_zero;
                    end
                    3'b101: begin
                        if (f7_zero)
                            dec_ctrl = ALU_SRL;
                        else if (f7_alt)
                            dec_ctrl = ALU_SRA;
                        else
                            dec_ill = 1'b1;
                    end
                    3'b110: begin
                        dec_ctrl = ALU_OR;
                        dec_ill  = is_r && !f7_zero;
                    end
                    3'b111: begin
                        dec_ctrl = ALU_AND;
                        dec_ill  = is_r && !f7_zero;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OP_LOAD, OP_STORE: begin
                dec_in1 = rs1_data;
                dec_in2 = imm;
            end
            OP_BR: begin
                dec_ctrl = ALU_SUB;
                dec_in1  = rs1_data;
                dec_in2  = rs2_data;
                dec_ill  = (funct3 != 3'b000) && (funct3 != 3'b001);
            end
            OP_LUI: begin
                dec_in2 = imm;
            end
            OP_AUIPC: begin
                dec_in1 = pc;
                dec_in2 = imm;
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal entries still travel down the queue, but carry a neutral payload
        if (dec_ill) begin
            dec_ctrl = ALU_ADD;
            dec_in1  = '0;
            dec_in2  = '0;
        end
    end

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wr_ptr] <= '{ill: dec_ill, ctrl: dec_ctrl, in1: dec_in1, in2: dec_in2};
    end

    // Storage is not reset, so the head is masked to zero whenever the queue is empty
    assign head     = mem[rd_ptr];
    assign alu_in1  = out_valid ? head.in1  : '0;
    assign alu_in2  = out_valid ? head.in2  : '0;
    assign alu_ctrl = out_valid ? head.ctrl : ALU_ADD;
    assign illegal  = out_valid ? head.ill  : 1'b0;

endmodule
